// File: rtl/axis_vec_pkg.sv
// Shared definitions for the AXIS <-> vector serialiser/deserialiser pair:
// counter sizing and the slot-order endpoints both sides must agree on.
package axis_vec_pkg;

    typedef enum logic {
        ASSEMBLE = 1'b0,
        DROP     = 1'b1
    } a2v_state_t;

    function automatic int ctr_width(input int vec_bytes, input int axis_bytes);
        int ctr_max;
        ctr_max = vec_bytes / axis_bytes - 1;
        if (ctr_max == 0) begin
            return 1;
        end else begin
            return $clog2(ctr_max + 1);
        end
    endfunction

    // first_slot=1 gives the slot of the first beat, first_slot=0 the slot of the final beat
    function automatic int ctr_bound(input int ctr_max, input bit msb_first, input bit first_slot);
        if (msb_first == first_slot) begin
            return ctr_max;
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/axis_beat_ctr.sv
// Beat slot counter: walks CTR_INIT -> CTR_LAST in slot order and wraps back.
module axis_beat_ctr
    import axis_vec_pkg::*;
#(
    parameter int CTR_MAX   = 0,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = ctr_width(CTR_MAX + 1, 1)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          step,
    input  logic          clear,
    output logic [CW-1:0] ctr,
    output logic          is_last
);

    localparam logic [CW-1:0] CTR_INIT = CW'(ctr_bound(CTR_MAX, MSB_FIRST, 1'b1));
    localparam logic [CW-1:0] CTR_LAST = CW'(ctr_bound(CTR_MAX, MSB_FIRST, 1'b0));
    localparam logic [CW-1:0] CTR_ONE  = CW'(1);

    logic [CW-1:0] ctr_r;
    logic [CW-1:0] ctr_next_s;

    // next slot in traversal order, wrapping at the final slot
    always_comb begin
        ctr_next_s = ctr_r;
        if (ctr_r == CTR_LAST) begin
            ctr_next_s = CTR_INIT;
        end else if (MSB_FIRST) begin
            ctr_next_s = ctr_r - CTR_ONE;
        end else begin
            ctr_next_s = ctr_r + CTR_ONE;
        end
    end

    // counter register; clear takes priority over step
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ctr_r <= CTR_INIT;
        end else if (clear) begin
            ctr_r <= CTR_INIT;
        end else if (step) begin
            ctr_r <= ctr_next_s;
        end else begin
            ctr_r <= ctr_r;
        end
    end

    assign ctr     = ctr_r;
    assign is_last = (ctr_r == CTR_LAST);

endmodule

// File: rtl/axis_to_vector.sv
// Collects CTR_MAX+1 AXIS beats into one registered wide vector with a
// valid/ready output and tlast framing checks (err_short / err_long pulses).
module axis_to_vector
    import axis_vec_pkg::*;
#(
    parameter int VEC_BYTES     = 1,
    parameter int AXIS_BYTES    = 1,
    parameter bit MSB_FIRST     = 1'b0,
    parameter bit REQUIRE_TLAST = 1'b1
) (
    input  logic                    clk,
    input  logic                    aresetn,
    output logic                    axis_tready,
    input  logic                    axis_tvalid,
    input  logic                    axis_tlast,
    input  logic [AXIS_BYTES*8-1:0] axis_tdata,
    output logic [VEC_BYTES*8-1:0]  vec,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    err_short,
    output logic                    err_long
);

    localparam int CTR_MAX = VEC_BYTES / AXIS_BYTES - 1;
    localparam int CW      = ctr_width(VEC_BYTES, AXIS_BYTES);
    localparam int SLOT_W  = AXIS_BYTES * 8;
    localparam int VEC_W   = VEC_BYTES * 8;

    a2v_state_t       state_r, state_s;
    logic             aresetn_q_r;
    logic [VEC_W-1:0] asm_r, asm_next_s;
    logic [VEC_W-1:0] vec_r;
    logic             vec_valid_r, err_short_r, err_long_r;
    logic [CW-1:0]    ctr_s;
    logic             is_last_s, tready_s, beat_acc_s;
    logic             store_s, complete_s, short_s, long_s, ctr_step_s, ctr_clear_s;

    axis_beat_ctr #(
        .CTR_MAX   (CTR_MAX),
        .MSB_FIRST (MSB_FIRST)
    ) u_ctr (
        .clk     (clk),
        .aresetn (aresetn),
        .step    (ctr_step_s),
        .clear   (ctr_clear_s),
        .ctr     (ctr_s),
        .is_last (is_last_s)
    );

    // tready stays low until the first edge after reset release
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            aresetn_q_r <= 1'b0;
        end else begin
            aresetn_q_r <= 1'b1;
        end
    end

    // only the final beat can stall; earlier beats fill the assembly buffer behind a held vec
    assign tready_s   = aresetn_q_r &&
                        !((state_r == ASSEMBLE) && is_last_s && vec_valid_r && !vec_ready);
    assign beat_acc_s = axis_tvalid && tready_s;

    // assembly contents with the current beat dropped into its slot
    always_comb begin
        asm_next_s = asm_r;
        for (int k = 0; k <= CTR_MAX; k++) begin
            if (ctr_s == CW'(k)) begin
                asm_next_s[k*SLOT_W +: SLOT_W] = axis_tdata;
            end else begin
                asm_next_s[k*SLOT_W +: SLOT_W] = asm_r[k*SLOT_W +: SLOT_W];
            end
        end
    end

    // framing FSM: next state and per-beat strobes
    always_comb begin
        state_s     = state_r;
        store_s     = 1'b0;
        complete_s  = 1'b0;
        short_s     = 1'b0;
        long_s      = 1'b0;
        ctr_step_s  = 1'b0;
        ctr_clear_s = 1'b0;
        case (state_r)
            ASSEMBLE: begin
                if (!beat_acc_s) begin
                    state_s = ASSEMBLE;
                end else if (!is_last_s) begin
                    if (axis_tlast && REQUIRE_TLAST) begin
                        short_s     = 1'b1;
                        ctr_clear_s = 1'b1;
                    end else begin
                        store_s    = 1'b1;
                        ctr_step_s = 1'b1;
                    end
                end else if (axis_tlast || !REQUIRE_TLAST) begin
                    complete_s = 1'b1;
                    ctr_step_s = 1'b1;
                end else begin
                    long_s      = 1'b1;
                    ctr_clear_s = 1'b1;
                    state_s     = DROP;
                end
            end
            DROP: begin
                if (beat_acc_s && axis_tlast) begin
                    ctr_clear_s = 1'b1;
                    state_s     = ASSEMBLE;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                ctr_clear_s = 1'b1;
                state_s     = ASSEMBLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ASSEMBLE;
        end else begin
            state_r <= state_s;
        end
    end

    // assembly buffer, output vector and error pulses
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            asm_r       <= '0;
            vec_r       <= '0;
            vec_valid_r <= 1'b0;
            err_short_r <= 1'b0;
            err_long_r  <= 1'b0;
        end else begin
            if (store_s) begin
                asm_r <= asm_next_s;
            end
            if (complete_s) begin
                vec_r       <= asm_next_s;
                vec_valid_r <= 1'b1;
            end else if (vec_ready) begin
                vec_valid_r <= 1'b0;
            end
            err_short_r <= short_s;
            err_long_r  <= long_s;
        end
    end

    assign axis_tready = tready_s;
    assign vec         = vec_r;
    assign vec_valid   = vec_valid_r;
    assign err_short   = err_short_r;
    assign err_long    = err_long_r;

endmodule

// File: tb/tb_axis_to_vector.sv
// Four 32-bit configurations (LSB/MSB-first, 16-bit beats, tlast ignored),
// each with directed frames and random traffic checked against a beat-count model.
module tb_axis_to_vector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] EXP_A [4] = '{32'h44332211, 32'h11223344, 32'h44332211, 32'h44332211};
    localparam logic [31:0] EXP_B [4] = '{32'hDDCCBBAA, 32'hAABBCCDD, 32'hDDCCBBAA, 32'hBBAA0201};

    task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL inst%0d %s: got %h, expected %h", g, nm, act, want);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : inst
        localparam int AB  = (g == 2) ? 2 : 1;
        localparam bit MSB = (g == 1);
        localparam bit REQ = (g != 3);
        localparam int N   = 4 / AB;

        logic          rstn = 1'b0, tvalid = 1'b0, tlast = 1'b0, vrdy = 1'b0;
        logic [AB*8-1:0] tdata = '0;
        logic          tready, vvalid, es, el;
        logic [31:0]   vec;
        bit            fin = 1'b0;

        axis_to_vector #(
            .VEC_BYTES(4), .AXIS_BYTES(AB), .MSB_FIRST(MSB), .REQUIRE_TLAST(REQ)
        ) dut (
            .clk(clk), .aresetn(rstn), .axis_tready(tready), .axis_tvalid(tvalid),
            .axis_tlast(tlast), .axis_tdata(tdata), .vec(vec), .vec_valid(vvalid),
            .vec_ready(vrdy), .err_short(es), .err_long(el)
        );

        // model: n = beats collected in the current frame, drop = discarding an overrun
        int          n = 0;
        bit          drop = 1'b0, rq = 1'b0, m_valid = 1'b0, m_es = 1'b0, m_el = 1'b0;
        logic [31:0] m_vec = '0, m_asm = '0;

        task automatic cycle(input logic v, input logic l, input logic [AB*8-1:0] d,
                             input logic rdy, input logic r, output logic acc);
            logic exp_tr;
            bit   done_v;
            int   slot;
            @(negedge clk);
            tvalid = v; tlast = l; tdata = d; vrdy = rdy; rstn = r;
            #1;
            if (!r) begin
                n = 0; drop = 1'b0; rq = 1'b0; m_valid = 1'b0;
                m_es = 1'b0; m_el = 1'b0; m_vec = '0; m_asm = '0;
            end
            exp_tr = rq && !(!drop && (n == N - 1) && m_valid && !rdy);
            chk(g, "tready", 32'(tready), 32'(exp_tr));
            chk(g, "vec", vec, m_vec);
            chk(g, "vec_valid", 32'(vvalid), 32'(m_valid));
            chk(g, "err_short", 32'(es), 32'(m_es));
            chk(g, "err_long", 32'(el), 32'(m_el));
            acc = v && exp_tr;
            if (r) begin
                done_v = 1'b0;
                m_es = 1'b0;
                m_el = 1'b0;
                slot = MSB ? (N - 1 - n) : n;
                if (acc) begin
                    if (drop) begin
                        if (l) begin drop = 1'b0; n = 0; end
                    end else if (n < N - 1) begin
                        if (l && REQ) begin
                            n = 0; m_es = 1'b1;
                        end else begin
                            m_asm[slot*AB*8 +: AB*8] = d; n++;
                        end
                    end else if (l || !REQ) begin
                        m_asm[slot*AB*8 +: AB*8] = d; m_vec = m_asm; done_v = 1'b1; n = 0;
                    end else begin
                        m_el = 1'b1; drop = 1'b1; n = 0;
                    end
                end
                if (done_v) m_valid = 1'b1;
                else if (rdy) m_valid = 1'b0;
                rq = 1'b1;
            end
        endtask

        task automatic send(input logic l, input logic [AB*8-1:0] d, input logic rdy);
            logic a;
            a = 1'b0;
            for (int k = 0; k < 20 && !a; k++) cycle(1'b1, l, d, rdy, 1'b1, a);
            if (!a) begin
                checks++; errors++;
                $display("FAIL inst%0d send_timeout: got no acceptance, expected within 20 cycles", g);
            end
        endtask

        task automatic send_seq(input logic [63:0] bs, input int nb, input logic last, input logic rdy);
            for (int i = 0; i < nb / AB; i++) send((i == nb / AB - 1) && last, bs[i*AB*8 +: AB*8], rdy);
        endtask

        task automatic idle(input int k, input logic rdy);
            logic a;
            for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, '0, rdy, 1'b1, a);
        endtask

        initial begin : run
            logic          a, v, l, rdy, r;
            logic [31:0]   rnd;
            logic [63:0]   f2;
            int            fi, len, p;
            for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, a);
            chk(g, "rst_vec", vec, 32'h0);
            idle(2, 1'b1);
            send_seq(64'h44332211, 4, 1'b1, 1'b1);
            idle(1, 1'b1);
            chk(g, "pin_vec_a", vec, EXP_A[g]);
            chk(g, "pin_model_a", m_vec, EXP_A[g]);
            send_seq(64'h0201, 2, 1'b1, 1'b1);
            send_seq(64'hDDCCBBAA, 4, 1'b1, 1'b1);
            idle(1, 1'b1);
            chk(g, "pin_vec_b", vec, EXP_B[g]);
            chk(g, "pin_model_b", m_vec, EXP_B[g]);
            send_seq(64'h060504030201, 6, 1'b1, 1'b1);
            idle(2, 1'b1);
            send_seq(64'h44332211, 4, 1'b1, 1'b1);
            idle(1, 1'b1);
            // two frames with the consumer stalled, then release
            f2 = 64'h88776655;
            send_seq(64'h44332211, 4, 1'b1, 1'b0);
            send_seq(f2, 4 - AB, 1'b0, 1'b0);
            a = 1'b0;
            for (int k = 0; k < 3 && !a; k++) cycle(1'b1, 1'b1, f2[(4-AB)*8 +: AB*8], 1'b0, 1'b1, a);
            if (!a) send(1'b1, f2[(4-AB)*8 +: AB*8], 1'b1);
            idle(3, 1'b1);
            // reset in the middle of a frame
            send_seq(64'h0201, 2, 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, a);
            chk(g, "rst_mid_valid", 32'(vvalid), 32'h0);
            send_seq(64'h44332211, 4, 1'b1, 1'b1);
            idle(1, 1'b1);
            chk(g, "pin_after_reset", vec, EXP_A[g]);
            // random traffic with mostly well-formed, some short and long frames
            fi = 0;
            len = N;
            for (int c = 0; c < 1500; c++) begin
                v   = ($urandom_range(0, 3) != 0);
                l   = REQ ? (fi == len - 1) : ($urandom_range(0, 3) == 0);
                rnd = $urandom;
                rdy = ($urandom_range(0, 9) < 7);
                r   = ($urandom_range(0, 299) != 0);
                cycle(v, l, rnd[AB*8-1:0], rdy, r, a);
                if (!r) begin
                    fi = 0;
                end else if (a) begin
                    if (l) begin
                        fi = 0;
                        p = $urandom_range(0, 9);
                        len = (p < 7) ? N : ((p < 9) ? $urandom_range(1, N - 1) : $urandom_range(N + 1, N + 3));
                    end else begin
                        fi++;
                    end
                end
            end
            fin = 1'b1;
        end
    end

    initial begin : top
        int cyc;
        cyc = 0;
        while (!(inst[0].fin && inst[1].fin && inst[2].fin && inst[3].fin) && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(inst[0].fin && inst[1].fin && inst[2].fin && inst[3].fin)) begin
            checks++; errors++;
            $display("FAIL run_timeout: got unfinished instances after %0d cycles, expected all finished", cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
